// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder for the load/store stage.
// Takes one request at a time, stalls the pipeline for LATENCY edges,
// then commits the store or returns load data together with a one-cycle ack.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready; a request is accepted on the next unhalted edge
// WAIT  | request latched; counting down the remaining latency
// RESP  | access done; ack (and addr_err) presented for one cycle
//
// Every request passes through WAIT, even when LATENCY is 1. The ack
// therefore always appears in the cycle after edge LATENCY, and one access
// completes every LATENCY+2 cycles.
//
// Halt freezes every register, the storage included. ack and addr_err are
// masked while halt is high, so an ack whose RESP cycle was halted shows up
// once, in the first unhalted cycle.
module mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_halt_sys,
    input  logic              i_req,
    input  logic              i_write_en,
    input  logic [15:0]       i_address,
    input  logic [DATA_W-1:0] i_write_data,
    output logic              o_busy,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_addr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [15:0]        r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_ack;
    logic               r_addr_err;
    logic [DATA_W-1:0]  r_data_out;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_in_range;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_access;
    logic               w_store;

    // Decode the latched request: word index, range check, and when the access happens
    always_comb begin
        w_in_range = (r_addr[15:ADDR_W] == '0);
        w_idx      = r_addr[ADDR_W-1:0];
        w_access   = !i_halt_sys && (r_state == ST_WAIT) && (r_cnt == '0);
        w_store    = w_access && r_we && w_in_range;
    end

    // Request FSM: latch, count down, respond; everything holds under halt
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ack      <= 1'b0;
            r_addr_err <= 1'b0;
            r_data_out <= '0;
        end else if (!i_halt_sys) begin
            case (r_state)
                ST_IDLE: begin
                    r_ack      <= 1'b0;
                    r_addr_err <= 1'b0;
                    if (i_req) begin
                        r_we    <= i_write_en;
                        r_addr  <= i_address;
                        r_wdata <= i_write_data;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state    <= ST_RESP;
                        r_ack      <= 1'b1;
                        r_addr_err <= !w_in_range;
                        if (!r_we) begin
                            r_data_out <= w_in_range ? r_mem[w_idx] : '0;
                        end
                    end
                end
                ST_RESP: begin
                    r_ack      <= 1'b0;
                    r_addr_err <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_ack      <= 1'b0;
                    r_addr_err <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage: cleared on reset, written only by an in-range store at its access edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Outputs: busy decoded from state; ack and addr_err masked while halted
    always_comb begin
        o_busy     = (r_state != ST_IDLE);
        o_ack      = r_ack && !i_halt_sys;
        o_addr_err = r_addr_err && !i_halt_sys;
        o_data_out = r_data_out;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A uses LATENCY=2 and instance B
// uses LATENCY=1. Expected responses come from a reference memory model and
// are queued when a request is driven, then popped when ack is seen.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        halt_sys;
    logic        req_a;
    logic        req_b;
    logic        write_en;
    logic [15:0] address;
    logic [15:0] write_data;

    logic        busy_a, ack_a, err_a;
    logic [15:0] data_a;
    logic        busy_b, ack_b, err_b;
    logic [15:0] data_b;

    typedef struct {
        logic        we;
        logic [15:0] data;
        logic        err;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] mdl_a [256];
    logic [15:0] mdl_b [256];
    logic [15:0] last_a;
    logic [15:0] last_b;
    int          n_tests;
    int          n_fail;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_halt_sys   (halt_sys),
        .i_req        (req_a),
        .i_write_en   (write_en),
        .i_address    (address),
        .i_write_data (write_data),
        .o_busy       (busy_a),
        .o_ack        (ack_a),
        .o_data_out   (data_a),
        .o_addr_err   (err_a)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_halt_sys   (halt_sys),
        .i_req        (req_b),
        .i_write_en   (write_en),
        .i_address    (address),
        .i_write_data (write_data),
        .o_busy       (busy_b),
        .o_ack        (ack_b),
        .o_data_out   (data_b),
        .o_addr_err   (err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
        last_a = '0;
        last_b = '0;
        sb.delete();
    endtask

    // Called just after a negedge. Halt is high in cycles hs..hs+hl-1, where
    // cycle j follows edge j and edge 0 accepts the request. With hold set,
    // req stays high and address switches to addr_mid once the request is taken.
    task automatic access(input bit dut_b, input logic we, input logic [15:0] addr,
                          input logic [15:0] wd, input int hs, input int hl,
                          input bit hold, input logic [15:0] addr_mid);
        sb_t         e;
        sb_t         got;
        logic [15:0] prev;
        logic        in_rng;
        int          lat, expc, dc, acks;
        logic        o_bsy, o_ak, o_er;
        logic [15:0] o_d;

        lat    = dut_b ? 1 : 2;
        expc   = lat + hl;
        dc     = (hl > 0 && hs < lat) ? lat + hl : lat;
        in_rng = (addr[15:8] == 8'h00);
        prev   = dut_b ? last_b : last_a;
        e.we   = we;
        e.err  = !in_rng;
        e.data = prev;
        if (we) begin
            if (in_rng) begin
                if (dut_b) mdl_b[addr[7:0]] = wd;
                else       mdl_a[addr[7:0]] = wd;
            end
        end else begin
            if (in_rng) e.data = dut_b ? mdl_b[addr[7:0]] : mdl_a[addr[7:0]];
            else        e.data = '0;
            if (dut_b) last_b = e.data;
            else       last_a = e.data;
        end
        sb.push_back(e);

        write_en   = we;
        address    = addr;
        write_data = wd;
        if (dut_b) req_b = 1'b1;
        else       req_a = 1'b1;

        acks = 0;
        for (int j = 0; j <= expc + 1; j++) begin
            @(posedge clk);
            #1;
            if (!hold) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end else if (j == 0) begin
                address = addr_mid;
            end
            halt_sys = (j >= hs) && (j < hs + hl);
            @(negedge clk);
            o_bsy = dut_b ? busy_b : busy_a;
            o_ak  = dut_b ? ack_b  : ack_a;
            o_er  = dut_b ? err_b  : err_a;
            o_d   = dut_b ? data_b : data_a;
            check("busy", 32'(o_bsy), 32'(j <= expc));
            if (o_ak) begin
                acks++;
                check("ack_cycle", 32'(j), 32'(expc));
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("ack_data", 32'(o_d), 32'(got.data));
                    check("ack_addr_err", 32'(o_er), 32'(got.err));
                end else begin
                    check("ack_unexpected", 32'(0), 32'(1));
                end
            end else begin
                check("addr_err_idle", 32'(o_er), 32'(0));
                check("data_hold", 32'(o_d), 32'((j < dc) ? prev : e.data));
            end
        end
        check("ack_count", 32'(acks), 32'(1));
        halt_sys = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        halt_sys   = 1'b0;
        req_a      = 1'b0;
        req_b      = 1'b0;
        write_en   = 1'b0;
        address    = '0;
        write_data = '0;
        clear_model();

        #12;
        check("rst_busy_a", 32'(busy_a), 32'(0));
        check("rst_ack_a",  32'(ack_a),  32'(0));
        check("rst_data_a", 32'(data_a), 32'(0));
        check("rst_err_a",  32'(err_a),  32'(0));
        check("rst_busy_b", 32'(busy_b), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // store then load at LATENCY=2
        access(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, 0, 1'b0, 16'h0005);
        access(1'b0, 1'b0, 16'h0005, 16'h0000, 0, 0, 1'b0, 16'h0005);

        // req held through busy with address changed mid-WAIT
        access(1'b0, 1'b1, 16'h0009, 16'h7777, 0, 0, 1'b0, 16'h0009);
        access(1'b0, 1'b0, 16'h0005, 16'h0000, 0, 0, 1'b1, 16'h0009);
        access(1'b0, 1'b0, 16'h0009, 16'h0000, 0, 0, 1'b0, 16'h0009);

        // out-of-range store is dropped, out-of-range load returns 0
        access(1'b0, 1'b1, 16'h0100, 16'hAAAA, 0, 0, 1'b0, 16'h0100);
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0, 16'h0000);
        access(1'b0, 1'b0, 16'h0100, 16'h0000, 0, 0, 1'b0, 16'h0100);

        // halt for 3 cycles in WAIT, then for 2 cycles in RESP
        access(1'b0, 1'b0, 16'h0005, 16'h0000, 0, 3, 1'b0, 16'h0005);
        access(1'b0, 1'b0, 16'h0009, 16'h0000, 2, 2, 1'b0, 16'h0009);

        // reset in the middle of a store's WAIT
        write_en   = 1'b1;
        address    = 16'h0003;
        write_data = 16'h1234;
        req_a      = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy_a), 32'(1));
        check("pre_rst_data", 32'(data_a), 32'(16'h7777));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_a), 32'(0));
        check("async_rst_ack",  32'(ack_a),  32'(0));
        check("async_rst_data", 32'(data_a), 32'(0));
        check("async_rst_err",  32'(err_a),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        access(1'b0, 1'b0, 16'h0003, 16'h0000, 0, 0, 1'b0, 16'h0003);

        // LATENCY=1 back-to-back with req held high
        access(1'b1, 1'b1, 16'h0010, 16'h1111, 0, 0, 1'b1, 16'h0010);
        access(1'b1, 1'b1, 16'h0011, 16'h2222, 0, 0, 1'b1, 16'h0011);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 1'b1, 16'h0010);
        access(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 0, 1'b1, 16'h0011);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0, 16'h0010);

        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
